// File: rtl/quiz_pkg.sv
// Shared types, limits and mm:ss helpers for the quiz countdown timer.
package quiz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } timer_state_t;

    typedef struct packed {
        logic [5:0] mins;
        logic [5:0] secs;
    } mmss_t;

    localparam logic [5:0]  MAX_MINS  = 6'd59;
    localparam logic [5:0]  MAX_SECS  = 6'd59;
    localparam logic [11:0] MAX_TOTAL = 12'd3599;

    // Constant-divisor split of a 0..3599 total into minutes and seconds.
    function automatic mmss_t split_total(input logic [11:0] total);
        mmss_t r;
        r.mins = 6'(total / 12'd60);
        r.secs = 6'(total % 12'd60);
        return r;
    endfunction

    function automatic logic [11:0] join_total(input logic [5:0] mins, input logic [5:0] secs);
        return ({6'd0, mins} * 12'd60) + {6'd0, secs};
    endfunction

    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > MAX_SECS) ? MAX_SECS : v;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides CLK down to a one-cycle wrap pulse every CLK_HZ enabled cycles.
module sec_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic CLK,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Holding while en is low is what preserves a paused partial second.
    always_ff @(posedge CLK) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quiz_countdown_timer.sv
// Per-question mm:ss countdown with load, start/pause, bonus/penalty adjust and expiry flags.
module quiz_countdown_timer
    import quiz_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEFAULT_MINS = 2,
    parameter int DEFAULT_SECS = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [5:0]  LOAD_MINS,
    input  logic [5:0]  LOAD_SECS,
    input  logic        START,
    input  logic        PAUSE,
    input  logic        ADJ,
    input  logic        ADJ_SUB,
    input  logic [7:0]  ADJ_SECS,
    output logic [5:0]  mins,
    output logic [5:0]  secs,
    output logic [11:0] rem,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse,
    output logic        tick
);

    localparam logic [5:0]  DEF_MINS = 6'(DEFAULT_MINS);
    localparam logic [5:0]  DEF_SECS = 6'(DEFAULT_SECS);
    localparam logic [11:0] DEF_REM  = ({6'd0, DEF_MINS} * 12'd60) + {6'd0, DEF_SECS};

    timer_state_t      state_r, state_n;
    logic [5:0]        mins_n, secs_n;
    logic [11:0]       rem_n;
    logic              tick_n, xp_n;
    logic              psc_clr, wrap;
    logic signed [13:0] adj_sum;
    logic [11:0]       adj_total;
    mmss_t             adj_mmss;

    function automatic logic [11:0] sat_total(input logic signed [13:0] v);
        if (v < 14'sd0) begin
            return 12'd0;
        end
        if (v > 14'sd3599) begin
            return MAX_TOTAL;
        end
        return v[11:0];
    endfunction

    assign adj_sum   = ADJ_SUB ? ($signed({2'b00, rem}) - $signed({6'd0, ADJ_SECS}))
                               : ($signed({2'b00, rem}) + $signed({6'd0, ADJ_SECS}));
    assign adj_total = sat_total(adj_sum);
    assign adj_mmss  = split_total(adj_total);

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .CLK (CLK),
        .en  (state_r == RUN),
        .clr (RESET || psc_clr),
        .wrap(wrap)
    );

    // Priority chain: LOAD > ADJ > second event > PAUSE > START.
    always_comb begin
        state_n = state_r;
        mins_n  = mins;
        secs_n  = secs;
        rem_n   = rem;
        tick_n  = 1'b0;
        xp_n    = 1'b0;
        psc_clr = 1'b0;
        if (LOAD) begin
            state_n = IDLE;
            mins_n  = clamp59(LOAD_MINS);
            secs_n  = clamp59(LOAD_SECS);
            rem_n   = join_total(mins_n, secs_n);
            psc_clr = 1'b1;
        end else if (ADJ && state_r != EXPIRED) begin
            mins_n = adj_mmss.mins;
            secs_n = adj_mmss.secs;
            rem_n  = adj_total;
            if (adj_total == 12'd0 && state_r != IDLE) begin
                state_n = EXPIRED;
                xp_n    = 1'b1;
            end
        end else if (wrap) begin
            if (secs != 6'd0) begin
                secs_n = secs - 6'd1;
            end else begin
                secs_n = MAX_SECS;
                mins_n = mins - 6'd1;
            end
            rem_n = rem - 12'd1;
            if (rem == 12'd1) begin
                state_n = EXPIRED;
                xp_n    = 1'b1;
            end else begin
                tick_n = 1'b1;
            end
        end else if (PAUSE) begin
            if (state_r == RUN) begin
                state_n = PAUSED;
            end
        end else if (START) begin
            case (state_r)
                IDLE: begin
                    psc_clr = 1'b1;
                    if (rem == 12'd0) begin
                        state_n = EXPIRED;
                        xp_n    = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                PAUSED:  state_n = RUN;
                default: state_n = state_r;
            endcase
        end
    end

    // mins/secs/rem share one edge so the display never sees a torn value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= IDLE;
            mins         <= DEF_MINS;
            secs         <= DEF_SECS;
            rem          <= DEF_REM;
            running      <= 1'b0;
            expired      <= 1'b0;
            tick         <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state_r      <= state_n;
            mins         <= mins_n;
            secs         <= secs_n;
            rem          <= rem_n;
            running      <= (state_n == RUN);
            expired      <= (state_n == EXPIRED);
            tick         <= tick_n;
            expire_pulse <= xp_n;
        end
    end

endmodule

// File: tb/tb_quiz_countdown_timer.sv
// Scoreboard bench: a seconds-total reference model predicts every cycle's outputs.
module tb_quiz_countdown_timer;

    localparam int CLK_HZ    = 4;
    localparam int DEF_M     = 1;
    localparam int DEF_S     = 7;
    localparam int DEF_TOTAL = DEF_M * 60 + DEF_S;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [5:0] lm;
        logic [5:0] ls;
        logic       start;
        logic       pause;
        logic       adj;
        logic       sub;
        logic [7:0] amt;
    } stim_t;

    typedef struct packed {
        logic [5:0]  mins;
        logic [5:0]  secs;
        logic [11:0] rem;
        logic        running;
        logic        expired;
        logic        tick;
        logic        xp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD = 1'b0;
    logic [5:0]  LOAD_MINS = '0;
    logic [5:0]  LOAD_SECS = '0;
    logic        START = 1'b0;
    logic        PAUSE = 1'b0;
    logic        ADJ = 1'b0;
    logic        ADJ_SUB = 1'b0;
    logic [7:0]  ADJ_SECS = '0;
    logic [5:0]  mins, secs;
    logic [11:0] rem;
    logic        running, expired, expire_pulse, tick;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_total = DEF_TOTAL;
    int   m_st = S_IDLE;
    int   m_ph = 0;

    quiz_countdown_timer #(
        .CLK_HZ(CLK_HZ),
        .DEFAULT_MINS(DEF_M),
        .DEFAULT_SECS(DEF_S)
    ) dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_MINS(LOAD_MINS), .LOAD_SECS(LOAD_SECS),
        .START(START), .PAUSE(PAUSE), .ADJ(ADJ), .ADJ_SUB(ADJ_SUB), .ADJ_SECS(ADJ_SECS),
        .mins(mins), .secs(secs), .rem(rem), .running(running), .expired(expired),
        .expire_pulse(expire_pulse), .tick(tick)
    );

    always #5 CLK = ~CLK;

    function automatic int min59(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    // Drive one cycle of inputs and push the outputs the model says must follow the next edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   second;
        int   t;
        @(negedge CLK);
        RESET = s.rst; LOAD = s.load; LOAD_MINS = s.lm; LOAD_SECS = s.ls;
        START = s.start; PAUSE = s.pause; ADJ = s.adj; ADJ_SUB = s.sub; ADJ_SECS = s.amt;
        e = '0;
        if (s.rst) begin
            m_total = DEF_TOTAL; m_st = S_IDLE; m_ph = 0;
        end else begin
            second = (m_st == S_RUN) && (m_ph == CLK_HZ - 1);
            if (m_st == S_RUN) m_ph = (m_ph + 1) % CLK_HZ;
            if (s.load) begin
                m_total = min59(int'(s.lm)) * 60 + min59(int'(s.ls));
                m_st = S_IDLE; m_ph = 0;
            end else if (s.adj && m_st != S_EXP) begin
                t = s.sub ? m_total - int'(s.amt) : m_total + int'(s.amt);
                if (t < 0) t = 0;
                if (t > 3599) t = 3599;
                m_total = t;
                if (t == 0 && m_st != S_IDLE) begin m_st = S_EXP; e.xp = 1'b1; end
            end else if (second) begin
                m_total = m_total - 1;
                if (m_total == 0) begin m_st = S_EXP; e.xp = 1'b1; end
                else e.tick = 1'b1;
            end else if (s.pause) begin
                if (m_st == S_RUN) m_st = S_PAUSED;
            end else if (s.start) begin
                if (m_st == S_IDLE) begin
                    m_ph = 0;
                    if (m_total == 0) begin m_st = S_EXP; e.xp = 1'b1; end
                    else m_st = S_RUN;
                end else if (m_st == S_PAUSED) begin
                    m_st = S_RUN;
                end
            end
        end
        e.mins = 6'(m_total / 60);
        e.secs = 6'(m_total % 60);
        e.rem = 12'(m_total);
        e.running = (m_st == S_RUN);
        e.expired = (m_st == S_EXP);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic do_reset();
        stim_t s = '0; s.rst = 1'b1; step(s);
    endtask

    task automatic do_load(input int m, input int sec);
        stim_t s = '0; s.load = 1'b1; s.lm = 6'(m); s.ls = 6'(sec); step(s);
    endtask

    task automatic do_start();
        stim_t s = '0; s.start = 1'b1; step(s);
    endtask

    task automatic do_pause();
        stim_t s = '0; s.pause = 1'b1; step(s);
    endtask

    task automatic do_adj(input bit sub, input int amt);
        stim_t s = '0; s.adj = 1'b1; s.sub = sub; s.amt = 8'(amt); step(s);
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {mins, secs, rem, running, expired, tick, expire_pulse};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got %0d:%0d rem=%0d run=%b exp=%b tick=%b xp=%b, want %0d:%0d rem=%0d run=%b exp=%b tick=%b xp=%b",
                             $time, a.mins, a.secs, a.rem, a.running, a.expired, a.tick, a.xp,
                             e.mins, e.secs, e.rem, e.running, e.expired, e.tick, e.xp);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int r;
        do_reset();
        idle(2);
        do_load(0, 3); do_start(); idle(14);
        do_load(1, 0); do_start(); idle(5);
        do_load(0, 10); do_start(); idle(1); do_pause(); idle(20); do_start(); idle(3);
        do_load(0, 10); do_start(); idle(2); do_adj(1'b1, 200); idle(2);
        do_load(59, 0); do_adj(1'b0, 255); idle(1);
        do_load(0, 30); do_start(); idle(3); do_adj(1'b0, 5); idle(5);
        do_load(63, 63); idle(2);
        do_load(0, 5); do_adj(1'b1, 9); idle(1);
        do_load(0, 8); do_start(); idle(2); do_reset(); idle(2);
        s = '0; s.start = 1'b1; s.pause = 1'b1; step(s); idle(2);
        do_load(0, 0); do_start(); do_adj(1'b0, 30); do_start(); idle(1);
        for (int i = 0; i < 600; i++) begin
            s = '0;
            r = $urandom_range(0, 99);
            if (r < 2) s.rst = 1'b1;
            else if (r < 8) begin
                s.load = 1'b1;
                s.lm = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
                s.ls = 6'($urandom_range(0, 63));
            end else if (r < 16) s.start = 1'b1;
            else if (r < 20) s.pause = 1'b1;
            else if (r < 26) begin
                s.adj = 1'b1;
                s.sub = 1'($urandom_range(0, 1));
                s.amt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
            end else if (r < 28) begin
                s.start = 1'b1; s.pause = 1'b1;
            end
            step(s);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge CLK);
            #2;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
